dmem_sized_ctrl: RTL and testbench
==================================

Name: dmem_sized_ctrl

Overview:
Parametrised MIPS data-memory controller, the next generation of the flat word RAM.
- Accesses: byte, halfword and word loads and stores, with byte lanes and sign/zero extension.
- Checks: alignment.
- Timing: configurable wait states behind a req/ready request handshake and an rvalid response pulse.
- Position: between the MEM pipeline stage and the on-chip RAM array.

Parameters:
- ADDR_W, 10, byte-address bits used; array holds 2**(ADDR_W-2) 32-bit words.
- WAIT_STATES, 1, extra cycles spent in ACCESS before response; legal range 0..7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- req  in  1  request valid.
- ready  out  1  controller can accept a request this cycle.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word; 11 reserved, treated as misaligned.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- rvalid  out  1  one-cycle response pulse, for loads and stores.
- rdata  out  32  load result, valid with rvalid; 0 for stores and errors.
- err  out  1  valid with rvalid; access was misaligned or out of range.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ready=1, rvalid=0, rdata=0, err=0, wait counter=0. Array contents are not reset.
- State IDLE: ready=1. On req&&ready, latch we, size, sign_ext, addr, wdata, then:
  - if the access is misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=11), go to RESP with err=1;
  - otherwise go to ACCESS with counter=WAIT_STATES.
- Inputs are ignored while ready=0.
- State ACCESS: ready=0.
  - While counter!=0, decrement.
  - When counter==0, perform the access and go to RESP.
  - Stores write only the enabled byte lanes on that edge.
  - Loads capture the word read asynchronously at latched addr[ADDR_W-1:2].
- State RESP: rvalid=1 and ready=0 for exactly one cycle, then IDLE.
- Latency: accept edge to rvalid is WAIT_STATES+2 cycles for aligned accesses and 1 cycle for errors. Throughput is one access per WAIT_STATES+3 cycles.
- Lane mapping is little-endian: byte offset addr[1:0]=k maps to bits [8k+7:8k].
  - Byte store: byte enable 1<<k, wdata[7:0] replicated to all lanes.
  - Half store: byte enable 0011 or 1100.
  - Word store: byte enable 1111.
- Load extraction: select the lane(s), then extend to 32 bits per sign_ext. Word loads ignore sign_ext.
- Address bits [31:ADDR_W] are ignored, so accesses wrap modulo 2**ADDR_W, unless the optional feature is enabled.
- Errors: misaligned stores do not modify memory; errored loads return rdata=0.
- rvalid, rdata and err are registered outputs. rdata and err return to 0 the cycle after RESP.
- Reset mid-operation: abort immediately, return to IDLE, and emit no response.
  - A store still in ACCESS with counter>0 is not written.
  - A store whose write edge coincides with reset assertion is undefined.
- req held high in RESP is not accepted; it is accepted the next cycle, in IDLE.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: an access with any of addr[31:ADDR_W] nonzero is treated as an error. It goes to RESP with err=1, performs no write, and returns rdata=0; latency is 1 cycle.
- Undefined: upper address bits are ignored and accesses wrap.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding IDLE/ACCESS/RESP;
  - MAX_WAIT=7.
- Sub-module dmem_byte_ram: 2**(ADDR_W-2) x 32 array, asynchronous read, synchronous write with 4-bit byte enable, no reset.
- Lane steering, extension and the FSM stay in the top module.

Test Plan:
- Word store/load, WAIT_STATES=1: store 0xDEADBEEF at 0x010, then load word at 0x010. rvalid arrives 3 cycles after each accept; rdata=0xDEADBEEF, err=0.
- Byte lanes and sign extension: after the previous step, store byte 0x80 at 0x012.
  - Load byte at 0x012 with sign_ext=1 gives 0xFFFFFF80; with sign_ext=0 gives 0x00000080.
  - Load word at 0x010 gives 0xDE80BEEF.
- Halfword: store 0x1234 at 0x022, then load half at 0x022 with sign_ext=1. Result is 0x00001234; word at 0x020 has upper half 0x1234 and lower half unchanged.
- Misaligned: store word at 0x013 gives rvalid 1 cycle after accept with err=1 and rdata=0. A subsequent load of the word at 0x010 returns 0xDE80BEEF, so memory is unmodified.
- Handshake and back-to-back: req held high continuously gives accepts spaced WAIT_STATES+3 cycles apart, with ready=0 during ACCESS and RESP.
- Reset mid-store: store 0xCAFEF00D at 0x030 with WAIT_STATES=3, assert rst_n low 1 cycle after accept.
  - No rvalid; outputs are at reset values.
  - Subsequent word load at 0x030 returns its prior contents.
- With DMEM_BOUNDS_CHECK_EN: load at 0x400 with ADDR_W=10 gives err=1 and rdata=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the sized data-memory controller.
//   - Size encodings for the size port.
//   - FSM state type.
//   - Upper bound on the wait-state count.
//   - Alignment helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned MAX_WAIT = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Reserved size 2'b11 is reported as misaligned.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    unique case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: 2**AW x 32-bit word array.
//   - Reads are asynchronous.
//   - Writes are synchronous, with a per-byte-lane enable.
//   - Contents are not reset.
// Ports:
//   clk   - rising-edge clock
//   we    - write strobe
//   be    - byte-lane enables, bit k covers bits [8k+7:8k]
//   addr  - word address, shared by read and write
//   wdata - write data, already steered to lanes
//   rdata - word at addr
module dmem_byte_ram #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_sized_ctrl.sv
// dmem_sized_ctrl: MIPS data-memory controller.
//   - Byte, halfword and word loads and stores, with little-endian lanes.
//   - Sign or zero extension on loads.
//   - Alignment checking.
//   - Configurable wait states.
// Handshake: a request is accepted on req && ready. A one-cycle rvalid pulse
// carries rdata and err.
// Optional macro DMEM_BOUNDS_CHECK_EN: any set address bit above ADDR_W is
// reported as an error instead of wrapping.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   req / ready                - request handshake
//   we, size, sign_ext         - access kind
//   addr, wdata                - byte address, right-justified store data
//   rvalid, rdata, err         - registered response
module dmem_sized_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned WaitClamp = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
  localparam logic [2:0]  WaitInit  = 3'(WaitClamp);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              capture, ram_we, bad_in, oob;
  logic [3:0]        be;
  logic [31:0]       ram_wdata, ram_rdata, shifted, load_val;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = |addr[31:ADDR_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W];
  assign oob            = 1'b0;
`endif

  assign bad_in = misaligned(size, addr[1:0]) | oob;

  // Store lane steering: replicate the data so the byte enable alone selects the lane.
  always_comb begin
    be        = 4'b1111;
    ram_wdata = wdata_q;
    unique case (size_q)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        ram_wdata = wdata_q;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  assign shifted = ram_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = ram_rdata;
    unique case (size_q)
      SZ_BYTE: load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: load_val = ram_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    capture  = 1'b0;
    ram_we   = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = 32'h0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          capture = 1'b1;
          if (bad_in) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = WaitInit;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          ram_we   = we_q;
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = we_q ? 32'h0 : load_val;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      sext_q   <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (capture) begin
        we_q    <= we;
        sext_q  <= sign_ext;
        size_q  <= size;
        addr_q  <= addr[ADDR_W-1:0];
        wdata_q <= wdata;
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

  dmem_byte_ram #(
    .AW(ADDR_W - 2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be),
    .addr  (addr_q[ADDR_W-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Scoreboard bench for dmem_sized_ctrl.
// Stimulus pushes the expected response into a queue.
// A negedge monitor pops and compares on every rvalid.
module tb_dmem_sized_ctrl;
  import dmem_pkg::*;

  localparam int unsigned WS = 1;
  localparam int unsigned AW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  dmem_sized_ctrl #(
    .ADDR_W      (AW),
    .WAIT_STATES (WS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ready    (ready),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
    end
  endtask

  // Monitor: compare each response against the oldest expectation.
  logic prev_rv = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rvalid: got rdata 0x%08h err %0b, want no response",
                   rdata, err);
        end else begin
          e = sbq.pop_front();
          check({e.name, "_rdata"}, rdata, e.rdata);
          check({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
          check({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          check({e.name, "_ready"}, {31'b0, ready}, 32'h0);
        end
      end else if (prev_rv) begin
        check("post_resp_rdata", rdata, 32'h0);
        check("post_resp_err", {31'b0, err}, 32'h0);
      end
    end
    prev_rv = rvalid && rst_n;
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: got ready 0, want 1 within 50 cycles");
    end
  endtask

  task automatic issue(input string name, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] er,
                       input logic ee);
    wait_ready();
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    sbq.push_back('{er, ee, cyc + 1, ee ? 1 : int'(WS) + 2, name});
    @(negedge clk);
    // Junk while busy must be ignored.
    req = 1'b0; we = 1'b1; size = SZ_HALF; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 32'(sbq.size()), 32'h0);
  endtask

  initial begin
    int last, lowcnt, acc, guard;
    rst_n = 1'b0;
    #1;
    check("reset_ready", {31'b0, ready}, 32'h1);
    check("reset_rvalid", {31'b0, rvalid}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word, byte-lane and sign-extension checks.
    issue("st_word_010", 1'b1, SZ_WORD, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    issue("ld_word_010", 1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    issue("st_byte_012", 1'b1, SZ_BYTE, 1'b0, 32'h012, 32'hAAAAAA80, 32'h0, 1'b0);
    issue("ld_byte_sx", 1'b0, SZ_BYTE, 1'b1, 32'h012, 32'h0, 32'hFFFFFF80, 1'b0);
    issue("ld_byte_zx", 1'b0, SZ_BYTE, 1'b0, 32'h012, 32'h0, 32'h00000080, 1'b0);
    issue("ld_word_merge", 1'b0, SZ_WORD, 1'b1, 32'h010, 32'h0, 32'hDE80BEEF, 1'b0);

    // Halfword lanes.
    issue("st_word_020", 1'b1, SZ_WORD, 1'b0, 32'h020, 32'h5A5AA5A5, 32'h0, 1'b0);
    issue("st_half_022", 1'b1, SZ_HALF, 1'b0, 32'h022, 32'hFFFF1234, 32'h0, 1'b0);
    issue("ld_half_022", 1'b0, SZ_HALF, 1'b1, 32'h022, 32'h0, 32'h00001234, 1'b0);
    issue("ld_word_020", 1'b0, SZ_WORD, 1'b0, 32'h020, 32'h0, 32'h1234A5A5, 1'b0);
    issue("ld_half_sx", 1'b0, SZ_HALF, 1'b1, 32'h020, 32'h0, 32'hFFFFA5A5, 1'b0);
    issue("ld_half_zx", 1'b0, SZ_HALF, 1'b0, 32'h020, 32'h0, 32'h0000A5A5, 1'b0);

    // Misalignment and reserved size.
    issue("st_word_mis", 1'b1, SZ_WORD, 1'b0, 32'h013, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue("ld_after_mis", 1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0, 32'hDE80BEEF, 1'b0);
    issue("ld_half_mis", 1'b0, SZ_HALF, 1'b1, 32'h011, 32'h0, 32'h0, 1'b1);
    issue("ld_size_rsvd", 1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 32'h0, 1'b1);

    // Top byte lane, then upper-address handling.
    issue("st_byte_013", 1'b1, SZ_BYTE, 1'b1, 32'h013, 32'h1234567F, 32'h0, 1'b0);
    issue("ld_byte_013", 1'b0, SZ_BYTE, 1'b1, 32'h013, 32'h0, 32'h0000007F, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    issue("ld_oob_400", 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
`else
    issue("ld_wrap_410", 1'b0, SZ_WORD, 1'b0, 32'h410, 32'h0, 32'h7F80BEEF, 1'b0);
`endif
    drain();

    // Back-to-back: req held high, accepts spaced WS+3 apart.
    wait_ready();
    req = 1'b1; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h020;
    last = -1; lowcnt = 0; acc = 0; guard = 0;
    while (acc < 3 && guard < 100) begin
      if (ready) begin
        sbq.push_back('{32'h1234A5A5, 1'b0, cyc + 1, int'(WS) + 2, "b2b_ld"});
        if (last >= 0) begin
          check("b2b_spacing", 32'(cyc - last), 32'(WS + 3));
          check("b2b_ready_low", 32'(lowcnt), 32'(WS + 2));
        end
        last = cyc;
        lowcnt = 0;
        acc++;
      end else begin
        lowcnt++;
      end
      @(negedge clk);
      guard++;
    end
    req = 1'b0;
    check("b2b_accepts", 32'(acc), 32'h3);
    drain();

    // Reset mid-store: aborted store must not reach the array.
    issue("st_word_030", 1'b1, SZ_WORD, 1'b0, 32'h030, 32'h11223344, 32'h0, 1'b0);
    issue("ld_word_030", 1'b0, SZ_WORD, 1'b0, 32'h030, 32'h0, 32'h11223344, 1'b0);
    drain();
    wait_ready();
    req = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h030; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, ready}, 32'h1);
    check("midrst_rvalid", {31'b0, rvalid}, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue("ld_after_rst", 1'b0, SZ_WORD, 1'b0, 32'h030, 32'h0, 32'h11223344, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
